handshake_sink: RTL and testbench

//  Destination-side consumer for the dclk end of the two-flop req/ack handshake synchronizer.

---
 rtl/handshake_sink.sv | 118 +++++++++++
 tb/tb_handshake_sink.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/handshake_sink.sv
`default_nettype none
// ============================================================================
// Module      : handshake_sink
// Description : dclk-side consumer of a req/ack handshake synchronizer.
//               Buffers words and streams them out as OUT_W-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_sink #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      word_cnt,
    output logic             err_ovf
);

    localparam int c_lanes = WIDTH / OUT_W;
    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cw    = c_aw + 1;
    localparam int c_lw    = (c_lanes > 1) ? $clog2(c_lanes) : 1;
    localparam logic [c_aw:0]   c_depth     = c_cw'(DEPTH);
    localparam logic [c_lw-1:0] c_last_lane = c_lw'(c_lanes - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_buf [DEPTH];
    logic [c_aw-1:0]     r_wr_ptr;
    logic [c_aw-1:0]     r_rd_ptr;
    logic [c_aw:0]       r_count;
    logic [c_aw:0]       w_count_next;
    logic [c_lw-1:0]     r_lane;
    logic                r_busy;
    logic                r_err;
    logic [15:0]         r_word_cnt;
    logic                w_push;
    logic                w_last;
    logic                w_fire;
    logic                w_pop;
    logic [WIDTH-1:0]    w_word;
    logic [OUT_W-1:0]    w_lane_data [c_lanes];

    assign w_word = r_buf[r_rd_ptr];

    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        assign w_lane_data[g] = w_word[g*OUT_W +: OUT_W];
    end

    always_comb begin
        w_push       = in_valid && !r_busy;
        w_last       = (r_state == S_SEND) && (r_lane == c_last_lane);
        w_fire       = (r_state == S_SEND) && out_ready;
        w_pop        = w_fire && w_last;
        w_count_next = r_count + c_cw'(w_push) - c_cw'(w_pop);
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (r_count != '0) w_state_next = S_SEND;
            S_SEND:  if (w_pop && (w_count_next == '0)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_lane     <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            // Busy is registered from the post-edge count so it never depends on in_valid combinationally.
            r_busy  <= (w_count_next == c_depth);
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (in_valid && r_busy) r_err <= 1'b1;
            if (r_state == S_IDLE) begin
                r_lane <= '0;
            end else if (w_fire) begin
                r_lane <= w_last ? '0 : r_lane + c_lw'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_aw'(1);
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    // Storage needs no reset; entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr_ptr] <= in_data;
    end

    assign in_busy   = r_busy;
    assign out_valid = (r_state == S_SEND);
    assign out_data  = (r_state == S_SEND) ? w_lane_data[r_lane] : '0;
    assign out_last  = w_last;
    assign word_cnt  = r_word_cnt;
    assign err_ovf   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_handshake_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_sink
// Description : Directed self-checking bench for handshake_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_sink;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_busy, out_valid, out_last, err_ovf;
    logic [7:0]  out_data;
    logic [15:0] word_cnt;

    logic        rst2_n, iv2, rdy2;
    logic [7:0]  din2;
    logic        busy2, ov2, last2, err2;
    logic [7:0]  dout2;
    logic [15:0] wc2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    handshake_sink #(.WIDTH(32), .OUT_W(8), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_busy(in_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .word_cnt(word_cnt),
        .err_ovf(err_ovf)
    );

    handshake_sink #(.WIDTH(8), .OUT_W(8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .in_valid(iv2), .in_data(din2),
        .in_busy(busy2), .out_valid(ov2), .out_ready(rdy2),
        .out_data(dout2), .out_last(last2), .word_cnt(wc2),
        .err_ovf(err2)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] din;
        logic        rdy;
        logic        ov;
        logic [7:0]  dout;
        logic        last;
        logic        busy;
        logic        err;
        logic [15:0] wc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic rdy,
                       input logic ov, input logic [7:0] dq, input logic lst,
                       input logic bsy, input logic er, input logic [15:0] wc);
        vec_t v;
        v.rst_n = r;  v.iv = iv;  v.din = d;  v.rdy = rdy;
        v.ov = ov;  v.dout = dq;  v.last = lst;  v.busy = bsy;  v.err = er;  v.wc = wc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  t3_bytes [4];
    logic [31:0] t5_words [8];

    initial begin
        int idx, nb, first_c, last_c, pushed, acc, nb2, bad;
        logic stall;
        logic [7:0] prev_data;
        logic seen_ffff;

        t3_bytes[0] = 8'hEF; t3_bytes[1] = 8'hBE; t3_bytes[2] = 8'hAD; t3_bytes[3] = 8'hDE;
        for (int k = 0; k < 8; k++) t5_words[k] = 32'h10203040 + 32'h01010101 * k;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst2_n = 1'b0; iv2 = 1'b0; din2 = '0; rdy2 = 1'b1;

        // reset, single word, full buffer with overflow, reset mid-word
        add(0,0,32'h0,0,        0,8'h00,0,0,0,16'd0);
        add(0,0,32'h0,0,        0,8'h00,0,0,0,16'd0);
        add(1,1,32'hA1B2C3D4,1, 0,8'h00,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'hD4,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'hC3,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'hB2,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'hA1,1,0,0,16'd0);
        add(1,0,32'h0,1,        0,8'h00,0,0,0,16'd1);
        add(1,1,32'h11111111,0, 0,8'h00,0,0,0,16'd1);
        add(1,1,32'h22222222,0, 1,8'h11,0,1,0,16'd1);
        add(1,1,32'h33333333,0, 1,8'h11,0,1,1,16'd1);
        add(1,0,32'h0,0,        1,8'h11,0,1,1,16'd1);
        add(1,0,32'h0,1,        1,8'h11,0,1,1,16'd1);
        add(1,0,32'h0,1,        1,8'h11,0,1,1,16'd1);
        add(1,0,32'h0,1,        1,8'h11,1,1,1,16'd1);
        add(1,0,32'h0,1,        1,8'h22,0,0,1,16'd2);
        add(1,0,32'h0,1,        1,8'h22,0,0,1,16'd2);
        add(1,0,32'h0,1,        1,8'h22,0,0,1,16'd2);
        add(1,0,32'h0,1,        1,8'h22,1,0,1,16'd2);
        add(1,0,32'h0,1,        0,8'h00,0,0,1,16'd3);
        add(0,0,32'h0,1,        0,8'h00,0,0,0,16'd0);
        add(1,1,32'hCAFEF00D,1, 0,8'h00,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'h0D,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'hF0,0,0,0,16'd0);
        add(0,0,32'h0,1,        0,8'h00,0,0,0,16'd0);
        add(1,1,32'h01020304,1, 0,8'h00,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'h04,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'h03,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'h02,0,0,0,16'd0);
        add(1,0,32'h0,1,        1,8'h01,1,0,0,16'd0);
        add(1,0,32'h0,1,        0,8'h00,0,0,0,16'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n; in_valid = tbl[i].iv; in_data = tbl[i].din; out_ready = tbl[i].rdy;
            if (i == 1) rst2_n = 1'b1;
            tick();
            chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d_data",  i), 32'(out_data),  32'(tbl[i].dout));
            chk($sformatf("row%0d_last",  i), 32'(out_last),  32'(tbl[i].last));
            chk($sformatf("row%0d_busy",  i), 32'(in_busy),   32'(tbl[i].busy));
            chk($sformatf("row%0d_err",   i), 32'(err_ovf),   32'(tbl[i].err));
            chk($sformatf("row%0d_wcnt",  i), 32'(word_cnt),  32'(tbl[i].wc));
        end
        in_valid = 1'b0;

        // ready toggling every cycle while one word drains
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = c[0];
            stall     = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) idx++;
            tick();
            if (idx == 4) break;
            if (out_valid) begin
                chk($sformatf("t3_beat%0d", idx), 32'(out_data), 32'(t3_bytes[idx]));
                chk($sformatf("t3_last%0d", idx), 32'(out_last), 32'(idx == 3));
                if (stall) chk("t3_hold", 32'(out_data), 32'(prev_data));
            end
        end
        chk("t3_beats", 32'(idx), 32'd4);
        chk("t3_idle", 32'(out_valid), 32'd0);
        chk("t3_wcnt", 32'(word_cnt), 32'd2);

        // one word per four cycles, new word landing on the final-beat edge
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        out_ready = 1'b1; nb = 0; pushed = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 60; c++) begin
            in_valid = 1'b0;
            if (pushed < 8 && (pushed == 0 || (out_valid && out_last))) begin
                in_valid = 1'b1; in_data = t5_words[pushed]; pushed++;
            end
            if (out_valid) begin
                chk($sformatf("t5_beat%0d", nb), 32'(out_data),
                    32'(t5_words[nb/4][(nb%4)*8 +: 8]));
                if (nb == 0) first_c = c;
                last_c = c;
                nb++;
            end
            tick();
            chk("t5_busy", 32'(in_busy), 32'd0);
            if (nb == 32) break;
        end
        in_valid = 1'b0;
        chk("t5_beats", 32'(nb), 32'd32);
        chk("t5_contig", 32'(last_c - first_c + 1), 32'd32);
        chk("t5_wcnt", 32'(word_cnt), 32'd8);

        // 65536 single-lane words to wrap word_cnt
        acc = 0; nb2 = 0; bad = 0; seen_ffff = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            iv2  = (acc < 65536) && !busy2;
            din2 = acc[7:0];
            if (iv2) acc++;
            if (ov2 && rdy2) begin
                if (dout2 !== nb2[7:0]) bad++;
                nb2++;
            end
            tick();
            if (nb2 == 65535 && !seen_ffff) begin
                seen_ffff = 1'b1;
                chk("t6_wcnt_ffff", 32'(wc2), 32'h0000FFFF);
            end
            if (nb2 == 65536) break;
        end
        iv2 = 1'b0;
        chk("t6_words", 32'(nb2), 32'd65536);
        chk("t6_wrap", 32'(wc2), 32'd0);
        chk("t6_err", 32'(err2), 32'd0);
        chk("t6_data", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
